// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution input loader: sample width,
// vector length, flat-bus packing constants and the loader FSM state enum.
package conv_pkg;

  localparam int DW    = 4;          // sample width in bits
  localparam int N     = 8;          // samples per vector (x and h each)
  localparam int IW    = $clog2(N);  // index counter width
  localparam int FW    = N * DW;     // flat bus width, lane i at [i*DW +: DW]
  localparam int CNT_W = 8;          // frame counter width

  typedef enum logic [1:0] {
    FILL_X = 2'd0,
    FILL_H = 2'd1,
    WAIT   = 2'd2
  } conv_state_t;

  // Low bit of lane i on a flat bus.
  function automatic int lane_lo(input int i);
    return i * DW;
  endfunction

endpackage

// File: rtl/conv_input_loader_if.sv
// Handshake and presentation bundle between the sample source, the loader
// and the convolution stage.
interface conv_input_loader_if;
  import conv_pkg::*;

  // Handshake rule for both channels: a transfer happens on a rising edge
  // where valid && ready; valid never waits on ready, and the loader's
  // s_ready depends on its state only.
  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             s_ready;
  logic             keep_h;
  logic [FW-1:0]    x_flat;
  logic [FW-1:0]    h_flat;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output s_valid, s_data, keep_h, out_ready,
    input  s_ready, x_flat, h_flat, out_valid, frame_cnt
  );

  modport slave (
    input  s_valid, s_data, keep_h, out_ready,
    output s_ready, x_flat, h_flat, out_valid, frame_cnt
  );

endinterface

// File: rtl/conv_sample_bank.sv
// N x DW working register bank with indexed write. The flat output already
// includes a write happening this cycle, so a frame can be captured on the
// same edge that its last sample arrives.
module conv_sample_bank
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [DW-1:0] wdata,
  output logic [FW-1:0] flat
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) begin
      flat[lane_lo(i) +: DW] = (we && (widx == IW'(i))) ? wdata : mem[i];
    end
  end

endmodule

// File: rtl/conv_input_loader.sv
// Double-buffered front end for the 8-tap circular convolution: assembles
// N x samples then N h samples into working banks and presents whole frames.
// Optional coefficient reuse is enabled by defining CONV_LOADER_HKEEP_EN.
module conv_input_loader
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  conv_input_loader_if.slave  bus,
  output conv_state_t         state_dbg
);

  conv_state_t      state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic             keep_lat, keep_n, keep_req;
  logic             s_ready, accept, last, complete, load;
  logic             wx_we, wh_we;
  logic [FW-1:0]    wx_flat, wh_flat;
  logic [FW-1:0]    ox, oh;
  logic             out_valid;
  logic [CNT_W-1:0] frame_cnt;

  assign s_ready = (state != WAIT);
  assign accept  = bus.s_valid && s_ready;
  assign last    = (idx == IW'(N - 1));

`ifdef CONV_LOADER_HKEEP_EN
  // Coefficients may only be reused once a real h vector has been captured.
  logic have_frame;

  always_ff @(posedge clk) begin
    if (rst)       have_frame <= 1'b0;
    else if (load) have_frame <= 1'b1;
  end

  assign keep_req = bus.keep_h && have_frame;
`else
  logic unused_keep_h;
  assign unused_keep_h = bus.keep_h;
  assign keep_req      = 1'b0;
`endif

  conv_sample_bank u_wx (
    .clk   (clk),
    .rst   (rst),
    .we    (wx_we),
    .widx  (idx),
    .wdata (bus.s_data),
    .flat  (wx_flat)
  );

  conv_sample_bank u_wh (
    .clk   (clk),
    .rst   (rst),
    .we    (wh_we),
    .widx  (idx),
    .wdata (bus.s_data),
    .flat  (wh_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= FILL_X;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    keep_n   = keep_lat;
    wx_we    = 1'b0;
    wh_we    = 1'b0;
    complete = 1'b0;
    load     = 1'b0;
    case (state)
      FILL_X: begin
        if (accept) begin
          wx_we = 1'b1;
          idx_n = idx + IW'(1);
          if (idx == '0) keep_n = keep_req;
          if (last) begin
            idx_n = '0;
            if (keep_lat) complete = 1'b1;
            else          state_n  = FILL_H;
          end
        end
      end
      FILL_H: begin
        if (accept) begin
          wh_we = 1'b1;
          idx_n = idx + IW'(1);
          if (last) begin
            idx_n    = '0;
            complete = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.out_ready) begin
          load    = 1'b1;
          state_n = FILL_X;
        end
      end
      default: state_n = FILL_X;
    endcase
    // A finished frame goes straight out unless the output bank is still owned.
    if (complete) begin
      if (!out_valid || bus.out_ready) begin
        load    = 1'b1;
        state_n = FILL_X;
      end else begin
        state_n = WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      keep_lat  <= 1'b0;
      ox        <= '0;
      oh        <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      idx      <= idx_n;
      keep_lat <= keep_n;
      if (load) begin
        ox        <= wx_flat;
        oh        <= wh_flat;
        out_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.x_flat    = ox;
  assign bus.h_flat    = oh;
  assign bus.out_valid = out_valid;
  assign bus.frame_cnt = frame_cnt;
  assign state_dbg     = state;

endmodule
